elixirchip_es1_spu_op_nop: RTL and testbench
============================================

Name: elixirchip_es1_spu_op_nop

Overview:
- Parameterised pipeline delay ("no-operation") element of the ES1 SPU operator library.
- Delays a data word by LATENCY clocks, with an optional synchronous clear-to-constant at the input stage.
- Used by other SPU operators (e.g. LUT, ALU wrappers) to pad their result path to a requested latency.

Parameters:
- LATENCY, 1, pipeline depth in clocks; must be >= 0; 0 = combinational pass-through.
- DATA_BITS, 1, width of s_data/m_data.
- data_t, logic [DATA_BITS-1:0], optional data type override.
- CLEAR_DATA, 'x, value loaded on clear and on reset; 'x means don't-care.
- DEVICE, "RTL", target device string; accepted values are "RTL" or any device name. All values use the generic RTL implementation.
- SIMULATION, "false", "true" enables simulation-only checks.
- DEBUG, "false", "true" marks pipeline registers keep/mark_debug.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, synchronous, active-high.
- cke  input  1  clock enable; 0 freezes all pipeline state.
- s_data  input  DATA_BITS  input data.
- s_clear  input  1  clear request; qualified by s_valid.
- s_valid  input  1  input valid; a stage updates only when its incoming valid is 1.
- m_data  output  DATA_BITS  delayed output data.

Behaviour:
- The design uses one clock. reset is synchronous and active-high.
- Stage 0 input value d0:
  - d0 = CLEAR_DATA when s_clear = 1 and s_valid = 1.
  - d0 = s_data otherwise.
- LATENCY = 0:
  - m_data = d0, purely combinational.
  - reset and cke are ignored.
  - When s_valid = 0, m_data = s_data.
- LATENCY = N >= 1: N register stages, each holding data[i] and valid[i].
  - Stage 1 loads d0 and s_valid.
  - Stage i > 1 loads data[i-1] and valid[i-1].
  - Per rising clk edge:
    - If reset = 1: all valid[i] <= 0 and all data[i] <= CLEAR_DATA, regardless of cke.
    - Else if cke = 1: valid[i] <= incoming valid. data[i] <= incoming data only when incoming valid = 1, otherwise data[i] holds.
    - Else (cke = 0): all state holds.
  - m_data = data[N].
- Latency is exactly N cke-qualified cycles from a valid input to m_data.
- Invalid inputs leave m_data at the last valid value once their bubble reaches the output.
- Clear applies only at the input stage. Data already in flight is unaffected by a later s_clear.
- s_clear = 1 with s_valid = 0 has no effect.
- Reset mid-stream:
  - The next cycle m_data = CLEAR_DATA.
  - All in-flight data is discarded.
  - Inputs presented in the reset cycle are dropped.
- Reset takes priority over cke = 0.
- Elaboration checks:
  - LATENCY < 0 causes $error.
  - DATA_BITS < 1 causes $error.
- SIMULATION = "true" adds a warning when s_data contains X while s_valid = 1.

Decomposition:
- Shared package elixirchip_es1_spu_pkg holds the DEVICE/SIMULATION/DEBUG string constants and the latency helper LATENCY1 = max(LATENCY, 1).
- Single module built from a generate loop over stages. No sub-module is needed; the stage is a simple always_ff.

Test Plan:
- Pipeline fill and flush: LATENCY=3, DATA_BITS=8, cke=1, s_valid=1, s_clear=0, s_data=8'h11,22,33,44 on cycles 0..3 -> m_data = 11,22,33,44 on cycles 3..6.
- Clear: LATENCY=3, CLEAR_DATA=8'h00.
  - Cycle 0: s_data=AA, s_clear=1, s_valid=1 -> m_data=00 at cycle 3.
  - Cycle 0 with s_clear=1, s_valid=0 -> no update.
- cke stall: LATENCY=2, data 0x5A entered, then cke=0 for 4 cycles -> m_data unchanged during the stall; 0x5A appears 2 enabled cycles after entry.
- Bubble hold: LATENCY=2, valid 0x01, then s_valid=0 with s_data=FF for 3 cycles -> m_data stays 0x01; FF never appears.
- Reset mid-operation: LATENCY=3, CLEAR_DATA=8'hC3, reset=1 for 1 cycle while 3 valid words are in flight -> m_data=C3 the next cycle; no in-flight word emerges afterwards. Also check reset with cke=0 still clears.
- Zero latency: LATENCY=0, s_data=7E -> m_data=7E in the same cycle. With s_clear=1, s_valid=1 and CLEAR_DATA=00 -> m_data=00 combinationally.

Source files
------------

// File: rtl/elixirchip_es1_spu_pkg.sv
// Shared definitions for the ES1 SPU operator library: option strings and
// small elaboration-time helpers used by the operator modules.
package elixirchip_es1_spu_pkg;

    localparam string SPU_DEVICE_RTL = "RTL";
    localparam string SPU_TRUE       = "true";
    localparam string SPU_FALSE      = "false";

    // Register count actually built for a requested latency; a zero-latency
    // operator still needs a well-formed (if unused) stage range.
    function automatic int latency1(input int latency);
        return (latency > 1) ? latency : 1;
    endfunction

endpackage

// File: rtl/elixirchip_es1_spu_op_nop.sv
// ES1 SPU no-operation element: delays a data word by LATENCY clock-enabled
// cycles, with an optional clear-to-constant applied at the input stage.
// Stages only advance their data on a valid input, so bubbles leave the
// last valid word on m_data.
module elixirchip_es1_spu_op_nop
    import elixirchip_es1_spu_pkg::*;
#(
    parameter int    LATENCY    = 1,
    parameter int    DATA_BITS  = 1,
    parameter type   data_t     = logic [DATA_BITS-1:0],
    parameter data_t CLEAR_DATA = 'x,
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false"
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  cke,
    input  data_t s_data,
    input  logic  s_clear,
    input  logic  s_valid,
    output data_t m_data
);

    // Elaboration-time parameter checks.
    if (LATENCY < 0) begin : g_err_latency
        $error("elixirchip_es1_spu_op_nop: LATENCY must be >= 0");
    end
    if (DATA_BITS < 1) begin : g_err_data_bits
        $error("elixirchip_es1_spu_op_nop: DATA_BITS must be >= 1");
    end
    if (DEVICE == "") begin : g_err_device
        $error("elixirchip_es1_spu_op_nop: DEVICE must not be empty");
    end
    if (SIMULATION != SPU_TRUE && SIMULATION != SPU_FALSE) begin : g_err_sim
        $error("elixirchip_es1_spu_op_nop: SIMULATION must be \"true\" or \"false\"");
    end
    if (DEBUG != SPU_TRUE && DEBUG != SPU_FALSE) begin : g_err_debug
        $error("elixirchip_es1_spu_op_nop: DEBUG must be \"true\" or \"false\"");
    end

    // Input-stage value: a qualified clear substitutes the constant.
    data_t d0;
    assign d0 = (s_clear && s_valid) ? CLEAR_DATA : s_data;

    if (LATENCY <= 0) begin : g_bypass
        assign m_data = d0;

        // Clock, reset and enable have no role in the combinational path.
        logic unused_ctl;
        assign unused_ctl = &{1'b0, clk, reset, cke};
    end else begin : g_pipe
        localparam int LATENCY1 = latency1(LATENCY);

        for (genvar i = 1; i <= LATENCY1; i++) begin : g_stage
            (* keep = DEBUG, mark_debug = DEBUG *) data_t data_p;
            (* keep = DEBUG, mark_debug = DEBUG *) logic  vld_p;
            data_t data_in;
            logic  vld_in;

            if (i == 1) begin : g_first
                assign data_in = d0;
                assign vld_in  = s_valid;
            end else begin : g_next
                assign data_in = g_stage[i-1].data_p;
                assign vld_in  = g_stage[i-1].vld_p;
            end

            // Stage register: reset beats cke; data advances only on valid.
            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_p  <= 1'b0;
                    data_p <= CLEAR_DATA;
                end else if (cke) begin
                    vld_p <= vld_in;
                    if (vld_in) begin
                        data_p <= data_in;
                    end
                end
            end
        end

        assign m_data = g_stage[LATENCY1].data_p;
    end

    if (SIMULATION == SPU_TRUE) begin : g_sim_check
        // Flag unknown bits on a word that is declared valid.
        always_ff @(posedge clk) begin
            if (s_valid && $isunknown(s_data)) begin
                $warning("elixirchip_es1_spu_op_nop: s_data contains X while s_valid=1");
            end
        end
    end

endmodule

// File: tb/tb_elixirchip_es1_spu_op_nop.sv
// Directed bench for elixirchip_es1_spu_op_nop: fill/flush, clear, cke stall,
// bubble hold, mid-stream reset and zero-latency pass-through.
`timescale 1ns/1ps
module tb_elixirchip_es1_spu_op_nop;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // DUT A: LATENCY=3, CLEAR=00 (fill/flush, clear)
    logic a_reset = 1'b1, a_cke = 1'b1, a_clear = 1'b0, a_valid = 1'b0;
    logic [7:0] a_data = 8'h00, a_m;
    // DUT B: LATENCY=2, CLEAR=00 (stall, bubble)
    logic b_reset = 1'b1, b_cke = 1'b1, b_clear = 1'b0, b_valid = 1'b0;
    logic [7:0] b_data = 8'h00, b_m;
    // DUT C: LATENCY=3, CLEAR=C3 (reset mid-stream)
    logic c_reset = 1'b1, c_cke = 1'b1, c_clear = 1'b0, c_valid = 1'b0;
    logic [7:0] c_data = 8'h00, c_m;
    // DUT D: LATENCY=0, CLEAR=00 (combinational)
    logic d_reset = 1'b0, d_cke = 1'b1, d_clear = 1'b0, d_valid = 1'b0;
    logic [7:0] d_data = 8'h00, d_m;

    elixirchip_es1_spu_op_nop #(.LATENCY(3), .DATA_BITS(8), .CLEAR_DATA(8'h00)) u_a (
        .clk(clk), .reset(a_reset), .cke(a_cke), .s_data(a_data),
        .s_clear(a_clear), .s_valid(a_valid), .m_data(a_m));
    elixirchip_es1_spu_op_nop #(.LATENCY(2), .DATA_BITS(8), .CLEAR_DATA(8'h00)) u_b (
        .clk(clk), .reset(b_reset), .cke(b_cke), .s_data(b_data),
        .s_clear(b_clear), .s_valid(b_valid), .m_data(b_m));
    elixirchip_es1_spu_op_nop #(.LATENCY(3), .DATA_BITS(8), .CLEAR_DATA(8'hC3)) u_c (
        .clk(clk), .reset(c_reset), .cke(c_cke), .s_data(c_data),
        .s_clear(c_clear), .s_valid(c_valid), .m_data(c_m));
    elixirchip_es1_spu_op_nop #(.LATENCY(0), .DATA_BITS(8), .CLEAR_DATA(8'h00)) u_d (
        .clk(clk), .reset(d_reset), .cke(d_cke), .s_data(d_data),
        .s_clear(d_clear), .s_valid(d_valid), .m_data(d_m));

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] din  [8];
    logic       vin  [8];
    logic       clr  [8];
    logic       ckin [8];
    logic [7:0] exp  [8];

    initial begin
        // Reset all pipelined instances for two edges.
        tick();
        tick();
        a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;
        check("reset_a", a_m, 8'h00);
        check("reset_b", b_m, 8'h00);
        check("reset_c", c_m, 8'hC3);

        // Fill and flush: 11,22,33,44 enter on cycles 0..3, appear on 3..6.
        din = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vin = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        for (int c = 0; c < 8; c++) begin
            a_data = din[c]; a_valid = vin[c]; a_clear = 1'b0;
            check($sformatf("fill_c%0d", c), a_m, exp[c]);
            tick();
        end

        // Clear: AA cleared, clear without valid ignored, in-flight 66 kept,
        // 77 cleared.
        din = '{8'hAA, 8'h55, 8'h66, 8'h77, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vin = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        clr = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp = '{8'h44, 8'h44, 8'h44, 8'h00, 8'h00, 8'h66, 8'h00, 8'h00};
        for (int c = 0; c < 8; c++) begin
            a_data = din[c]; a_valid = vin[c]; a_clear = clr[c];
            check($sformatf("clear_c%0d", c), a_m, exp[c]);
            tick();
        end

        // cke stall: 5A enters, four frozen cycles, then two enabled edges.
        din  = '{8'h5A, 8'h99, 8'h99, 8'h99, 8'h99, 8'hFF, 8'hFF, 8'hFF};
        vin  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        ckin = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5A, 8'h5A};
        for (int c = 0; c < 8; c++) begin
            b_data = din[c]; b_valid = vin[c]; b_cke = ckin[c];
            check($sformatf("stall_c%0d", c), b_m, exp[c]);
            tick();
        end

        // Bubble hold: 01 valid, then FF with s_valid=0 must never show.
        din = '{8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vin = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp = '{8'h5A, 8'h5A, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
        b_cke = 1'b1;
        for (int c = 0; c < 8; c++) begin
            b_data = din[c]; b_valid = vin[c];
            check($sformatf("bubble_c%0d", c), b_m, exp[c]);
            tick();
        end

        // Reset mid-stream: 10,20,30 in flight, reset in cycle 3 with 40 presented.
        din = '{8'h10, 8'h20, 8'h30, 8'h40, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vin = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        exp = '{8'hC3, 8'hC3, 8'hC3, 8'h10, 8'hC3, 8'hC3, 8'hC3, 8'hC3};
        for (int c = 0; c < 8; c++) begin
            c_data = din[c]; c_valid = vin[c]; c_reset = (c == 3);
            check($sformatf("rst_c%0d", c), c_m, exp[c]);
            tick();
        end

        // Reset with cke=0: 50 at output, 60 in flight, both gone afterwards.
        din  = '{8'h50, 8'h60, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        vin  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        ckin = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp  = '{8'hC3, 8'hC3, 8'hC3, 8'h50, 8'hC3, 8'hC3, 8'hC3, 8'hC3};
        for (int c = 0; c < 8; c++) begin
            c_data = din[c]; c_valid = vin[c]; c_cke = ckin[c]; c_reset = (c == 3);
            check($sformatf("rst_nocke_c%0d", c), c_m, exp[c]);
            tick();
        end

        // Zero latency: combinational pass-through and clear.
        d_data = 8'h7E; d_valid = 1'b1; d_clear = 1'b0; #1;
        check("zl_pass", d_m, 8'h7E);
        d_clear = 1'b1; #1;
        check("zl_clear", d_m, 8'h00);
        d_valid = 1'b0; #1;
        check("zl_clear_novalid", d_m, 8'h7E);
        d_clear = 1'b0; d_data = 8'h3C; #1;
        check("zl_invalid_pass", d_m, 8'h3C);
        d_reset = 1'b1; d_cke = 1'b0; d_valid = 1'b1; d_data = 8'hA5;
        tick();
        check("zl_ignore_reset", d_m, 8'hA5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
